unified_mem_port: RTL and testbench
===================================

# unified_mem_port

Initiator-side access controller for the core's single-ported unified instruction/data memory. It accepts instruction-fetch requests from IF and load/store requests from the MEM stage, and arbitrates between them with data priority and a fairness counter. It drives one memory access per cycle through a registered issue stage and returns captured read data to the correct requester with fixed latency. It also screens data requests for misalignment or illegal width before they reach memory.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of both the fetch and the data address spaces
- FAIR_MAX, 4, consecutive data grants allowed while a fetch waits before fetch is forced

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored and forced to 00
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_func3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- d_addr  in  ADDR_W  data byte offset within the data region
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid, or fault report
- d_rdata  out  32  load data, already extended by memory; 0 on fault
- d_fault  out  1  qualifies d_rvalid: access rejected
- m_isel  out  1  1 = instruction access, 0 = data access
- m_addr  out  ADDR_W  memory address
- m_re  out  1  memory data-read enable
- m_we  out  1  memory write enable
- m_func3  out  3  width code to memory
- m_wdata  out  32  write data
- m_rdata  in  32  combinational read data from memory

## Operation
- Arbitration, evaluated each cycle:
  - Only d_req high: grant data.
  - Only if_req high: grant fetch.
  - Both high: grant data unless fair_cnt == FAIR_MAX; in that case grant fetch.
- fair_cnt:
  - Increments on each data grant while if_req is high.
  - Clears on any fetch grant, and in any cycle if_req is low.
  - Saturates at FAIR_MAX.
- Exactly one gnt per cycle at most. A requester holds req, address and data stable until it sees gnt.
- Data legality checks:
  - Illegal: func3 ∈ {011, 110, 111}.
  - Illegal for stores: func3 ∈ {100, 101}.
  - Misaligned: h/hu with addr[0] = 1, or w with addr[1:0] ≠ 00.
- An illegal or misaligned data request is still granted. It is never issued to memory: m_re = m_we = 0 in its issue cycle. It returns d_rvalid = 1, d_fault = 1, d_rdata = 0.
- Issue stage (registered): the accepted request drives m_isel, m_addr, m_re (loads only), m_we (legal stores only), m_func3 and m_wdata for exactly one cycle. When idle, m_re and m_we are 0.
- Response stage: at the end of the issue cycle, m_rdata is captured into if_rdata or d_rdata according to the issue tag.
- Stores produce no d_rvalid unless they fault.

## Timing
- Grant in cycle N; memory signals valid in cycle N+1; rvalid/rdata valid in cycle N+2 for one cycle.
- Fully pipelined: one accepted request per cycle, with back-to-back grants permitted.
- Stores commit at the rising edge that ends cycle N+1. A load issued in the cycle after a store to the same address returns the new value.
- rdata outputs hold their last value when rvalid is 0. Faults force d_rdata to 0.
- Reset values: all outputs 0 (if_rdata, d_rdata, m_addr, m_wdata, m_func3 cleared); fair_cnt 0.
- Reset asserted mid-operation: in-flight issue and response are dropped, and m_we clears asynchronously, so a pending store does not commit. The first grant is possible in the first cycle after release.
- No response backpressure: requesters must accept rvalid when it occurs.

## Test plan
- Fetch only: memory preloaded with 0x00500093 at inst 0. if_req, if_addr = 0x03 at N -> if_gnt at N; m_isel = 1, m_addr = 0x00 at N+1; if_rvalid, if_rdata = 0x00500093 at N+2.
- Load word then byte: data word 0 = 17. lw addr 0, then lb addr 0 back-to-back -> d_rdata = 17 at N+2 and 17 at N+3; each m_re pulses one cycle.
- Store/load forwarding: sw 0xDEADBEEF at addr 4 at N, lw addr 4 at N+1 -> d_rdata = 0xDEADBEEF at N+3; no d_rvalid for the store.
- Faults: lw addr 2, sh addr 1, sbu (func3 = 100, store) -> each gnt, m_re = m_we = 0 in the issue cycle, d_rvalid = d_fault = 1, d_rdata = 0 two cycles after grant.
- Fairness: if_req and d_req held high continuously (FAIR_MAX = 4) -> grant pattern D,D,D,D,F repeating.
- Reset mid-store: sw granted at N, rst low during N+1 -> m_we is 0 immediately, memory is unchanged, all outputs are 0, and a grant occurs in the first cycle after release.

Source files
------------

// File: rtl/unified_mem_port_if.sv
// Bus bundle for unified_mem_port: fetch request/response, data request/response
// and the single-ported memory access channel.
// slave  : the access controller (consumes requests and m_rdata, drives grants,
//          responses and memory controls).
// master : the environment (IF stage, MEM stage and the memory itself).
interface unified_mem_port_if #(
    parameter int unsigned ADDR_W = 8
);
    // Fetch channel
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    // Data channel
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_func3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_fault;

    // Memory channel
    logic              m_isel;
    logic [ADDR_W-1:0] m_addr;
    logic              m_re;
    logic              m_we;
    logic [2:0]        m_func3;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_func3, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_fault,
        output m_isel, m_addr, m_re, m_we, m_func3, m_wdata,
        input  m_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_func3, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_fault,
        input  m_isel, m_addr, m_re, m_we, m_func3, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/unified_mem_port.sv
// Access controller for the single-ported unified instruction/data memory.
// Arbitrates fetch vs. data requests (data first, with a fairness limit), screens
// data requests for illegal width / misalignment, issues one registered memory
// access per cycle and returns captured read data two cycles after grant.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - unified_mem_port_if.slave: fetch channel (if_*), data channel (d_*),
//          memory channel (m_*); if_gnt/d_gnt are combinational, all else registered
module unified_mem_port #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned FAIR_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    unified_mem_port_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FAIR_MAX + 1);

    logic [CNT_W-1:0] fair_cnt;
    logic             fair_hit;
    logic             gnt_d;
    logic             gnt_f;
    logic             func3_bad;
    logic             store_bad;
    logic             misaligned;
    logic             d_bad;

    // Issue-stage tags: which response the captured m_rdata belongs to
    logic iss_f;
    logic iss_dl;
    logic iss_df;

    // Fetch addresses are word aligned; the byte-offset bits are intentionally dropped
    logic unused_if_low;
    assign unused_if_low = ^bus.if_addr[1:0];

    // Arbitration: data wins unless a waiting fetch has been passed over FAIR_MAX times
    always_comb begin
        fair_hit = (fair_cnt == CNT_W'(FAIR_MAX));
        gnt_d    = bus.d_req & ~(bus.if_req & fair_hit);
        gnt_f    = bus.if_req & ~gnt_d;
    end

    assign bus.if_gnt = gnt_f;
    assign bus.d_gnt  = gnt_d;

    // Data request screening
    always_comb begin
        func3_bad  = (bus.d_func3 == 3'b011) | (bus.d_func3 == 3'b110) |
                     (bus.d_func3 == 3'b111);
        store_bad  = bus.d_we & ((bus.d_func3 == 3'b100) | (bus.d_func3 == 3'b101));
        misaligned = ((bus.d_func3[1:0] == 2'b01) & bus.d_addr[0]) |
                     ((bus.d_func3[1:0] == 2'b10) & (bus.d_addr[1:0] != 2'b00));
        d_bad      = func3_bad | store_bad | misaligned;
    end

    // Fairness counter: counts data grants that bypassed a waiting fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fair_cnt <= '0;
        end else if (!bus.if_req || gnt_f) begin
            fair_cnt <= '0;
        end else if (gnt_d && !fair_hit) begin
            fair_cnt <= fair_cnt + CNT_W'(1);
        end
    end

    // Issue stage: one-cycle memory access for the request granted last cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.m_isel  <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_re    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_func3 <= 3'b000;
            bus.m_wdata <= '0;
            iss_f       <= 1'b0;
            iss_dl      <= 1'b0;
            iss_df      <= 1'b0;
        end else begin
            bus.m_re <= 1'b0;
            bus.m_we <= 1'b0;
            iss_f    <= 1'b0;
            iss_dl   <= 1'b0;
            iss_df   <= 1'b0;
            if (gnt_f) begin
                bus.m_isel  <= 1'b1;
                bus.m_addr  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                bus.m_func3 <= 3'b010;
                iss_f       <= 1'b1;
            end else if (gnt_d) begin
                bus.m_isel  <= 1'b0;
                bus.m_addr  <= bus.d_addr;
                bus.m_func3 <= bus.d_func3;
                bus.m_wdata <= bus.d_wdata;
                // Rejected requests travel down the pipe only as a fault tag
                bus.m_re    <= ~bus.d_we & ~d_bad;
                bus.m_we    <= bus.d_we & ~d_bad;
                iss_dl      <= ~bus.d_we & ~d_bad;
                iss_df      <= d_bad;
            end
        end
    end

    // Response stage: capture memory read data into the tagged requester
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_fault   <= 1'b0;
        end else begin
            bus.if_rvalid <= iss_f;
            bus.d_rvalid  <= iss_dl | iss_df;
            bus.d_fault   <= iss_df;
            if (iss_f) begin
                bus.if_rdata <= bus.m_rdata;
            end
            if (iss_dl) begin
                bus.d_rdata <= bus.m_rdata;
            end else if (iss_df) begin
                bus.d_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_port.sv
// Testbench for unified_mem_port: directed scenarios plus randomized traffic,
// checked against a transaction-level reference (byte-array memory, in-order
// expected-response slots, grant rule from the arbitration policy).
module tb_unified_mem_port;
    localparam int unsigned ADDR_W   = 8;
    localparam int          FAIR_MAX = 4;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } dreq_t;

    typedef struct {
        bit          valid;
        bit          isel;
        bit          fault;
        bit          load;
        bit          store;
        logic [7:0]  addr;
        logic [2:0]  f3;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;

    unified_mem_port_if #(.ADDR_W(ADDR_W)) bus ();

    unified_mem_port #(.ADDR_W(ADDR_W), .FAIR_MAX(FAIR_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device model (word storage) and reference memory (byte array)
    logic [31:0] imem   [64];
    logic [31:0] dmem_w [64];
    logic [7:0]  ref_b  [256];
    logic [31:0] rd_w;
    logic [31:0] rd_s;

    always_comb begin
        rd_w = dmem_w[bus.m_addr[7:2]];
        rd_s = rd_w >> {bus.m_addr[1:0], 3'b000};
        if (bus.m_isel) begin
            bus.m_rdata = imem[bus.m_addr[7:2]];
        end else begin
            case (bus.m_func3)
                3'b000:  bus.m_rdata = {{24{rd_s[7]}}, rd_s[7:0]};
                3'b001:  bus.m_rdata = {{16{rd_s[15]}}, rd_s[15:0]};
                3'b010:  bus.m_rdata = rd_w;
                3'b100:  bus.m_rdata = {24'h0, rd_s[7:0]};
                3'b101:  bus.m_rdata = {16'h0, rd_s[15:0]};
                default: bus.m_rdata = 32'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.m_we) begin
            case (bus.m_func3)
                3'b000:  dmem_w[bus.m_addr[7:2]][{bus.m_addr[1:0], 3'b000} +: 8] <= bus.m_wdata[7:0];
                3'b001:  dmem_w[bus.m_addr[7:2]][{bus.m_addr[1:0], 3'b000} +: 16] <= bus.m_wdata[15:0];
                default: dmem_w[bus.m_addr[7:2]] <= bus.m_wdata;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int d_streak = 0;
    int n_f_grants = 0;
    int p_f = 0;
    int p_d = 0;

    bit          f_pend = 0;
    logic [7:0]  f_addr = '0;
    bit          d_pend = 0;
    dreq_t       dcur;
    dreq_t       dq [$];
    logic [7:0]  fq [$];
    exp_t        pipe [4];
    logic [31:0] last_if = '0;
    logic [31:0] last_d  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_fault(logic we, logic [2:0] f3, logic [7:0] a);
        bit bad_w, bad_st, mis;
        bad_w  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        bad_st = we && ((f3 == 3'd4) || (f3 == 3'd5));
        mis    = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
        return bad_w || bad_st || mis;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [7:0] a);
        logic [7:0]  b0;
        logic [15:0] h;
        b0 = ref_b[a];
        h  = {ref_b[8'(a + 8'd1)], ref_b[a]};
        case (f3)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b0};
            3'd5:    return {16'h0, h};
            default: return {ref_b[8'(a + 8'd3)], ref_b[8'(a + 8'd2)], h};
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_b[8'(a + 8'(i))] = wd[8*i +: 8];
    endtask

    task automatic set_dword(input int idx, input logic [31:0] v);
        dmem_w[idx] = v;
        for (int i = 0; i < 4; i++) ref_b[idx*4 + i] = v[8*i +: 8];
    endtask

    task automatic check_reset_outs(input string pfx);
        check({pfx, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        check({pfx, "_if_rdata"},  bus.if_rdata, 32'd0);
        check({pfx, "_d_rvalid"},  32'(bus.d_rvalid), 32'd0);
        check({pfx, "_d_rdata"},   bus.d_rdata, 32'd0);
        check({pfx, "_d_fault"},   32'(bus.d_fault), 32'd0);
        check({pfx, "_m_isel"},    32'(bus.m_isel), 32'd0);
        check({pfx, "_m_addr"},    32'(bus.m_addr), 32'd0);
        check({pfx, "_m_re"},      32'(bus.m_re), 32'd0);
        check({pfx, "_m_we"},      32'(bus.m_we), 32'd0);
        check({pfx, "_m_func3"},   32'(bus.m_func3), 32'd0);
        check({pfx, "_m_wdata"},   bus.m_wdata, 32'd0);
    endtask

    // One clock cycle: present requests, check grants, issue and response, then record
    task automatic step();
        exp_t e, g, n;
        bit eg_d, eg_f, frq, dv;
        if (!f_pend) begin
            if (fq.size() > 0) begin
                f_pend = 1; f_addr = fq.pop_front();
            end else if (int'($urandom_range(99)) < p_f) begin
                f_pend = 1; f_addr = 8'($urandom);
            end
        end
        if (!d_pend) begin
            if (dq.size() > 0) begin
                d_pend = 1; dcur = dq.pop_front();
            end else if (int'($urandom_range(99)) < p_d) begin
                d_pend = 1;
                dcur.we = 1'($urandom);
                dcur.f3 = 3'($urandom);
                dcur.addr = 8'($urandom);
                if ($urandom_range(1) == 1) dcur.addr[1:0] = 2'b00;
                dcur.wdata = $urandom;
            end
        end
        bus.if_req  = f_pend;
        bus.if_addr = f_addr;
        bus.d_req   = d_pend;
        bus.d_we    = dcur.we;
        bus.d_func3 = dcur.f3;
        bus.d_addr  = dcur.addr;
        bus.d_wdata = dcur.wdata;
        #1;
        frq  = f_pend;
        eg_d = d_pend && !(f_pend && d_streak == FAIR_MAX);
        eg_f = f_pend && !eg_d;
        check("if_gnt", 32'(bus.if_gnt), 32'(eg_f));
        check("d_gnt", 32'(bus.d_gnt), 32'(eg_d));

        e = pipe[(cyc + 3) % 4];
        check("m_re", 32'(bus.m_re), 32'(e.valid && e.load));
        check("m_we", 32'(bus.m_we), 32'(e.valid && e.store));
        if (e.valid) begin
            check("m_isel", 32'(bus.m_isel), 32'(e.isel));
            if (!e.fault) check("m_addr", 32'(bus.m_addr), 32'(e.addr));
            if (e.load || e.store) check("m_func3", 32'(bus.m_func3), 32'(e.f3));
            if (e.store) check("m_wdata", bus.m_wdata, e.data);
        end

        g = pipe[(cyc + 2) % 4];
        check("if_rvalid", 32'(bus.if_rvalid), 32'(g.valid && g.isel));
        if (g.valid && g.isel) last_if = g.data;
        check("if_rdata", bus.if_rdata, last_if);
        dv = g.valid && !g.isel && (g.fault || g.load);
        check("d_rvalid", 32'(bus.d_rvalid), 32'(dv));
        check("d_fault", 32'(bus.d_fault), 32'(g.valid && !g.isel && g.fault));
        if (dv) last_d = g.data;
        check("d_rdata", bus.d_rdata, last_d);

        n = '{default: '0};
        if (eg_f) begin
            n.valid = 1; n.isel = 1; n.addr = f_addr & 8'hfc; n.f3 = 3'd2;
            n.data = imem[f_addr[7:2]];
            f_pend = 0;
            n_f_grants++;
        end else if (eg_d) begin
            n.valid = 1;
            n.fault = is_fault(dcur.we, dcur.f3, dcur.addr);
            n.load  = !dcur.we && !n.fault;
            n.store = dcur.we && !n.fault;
            n.addr  = dcur.addr;
            n.f3    = dcur.f3;
            if (n.load) n.data = ref_load(dcur.f3, dcur.addr);
            else if (n.store) begin
                n.data = dcur.wdata;
                ref_store(dcur.f3, dcur.addr, dcur.wdata);
            end
            d_pend = 0;
        end
        pipe[cyc % 4] = n;
        if (!frq || eg_f) d_streak = 0;
        else if (eg_d && d_streak < FAIR_MAX) d_streak++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic dreq_t mk(logic we, logic [2:0] f3, logic [7:0] a, logic [31:0] wd);
        dreq_t r;
        r.we = we; r.f3 = f3; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    initial begin
        logic [31:0] old_w;
        logic [7:0]  old_b [4];
        int fbase;
        for (int i = 0; i < 64; i++) begin
            imem[i] = $urandom;
            set_dword(i, $urandom);
        end
        imem[0] = 32'h0050_0093;
        set_dword(0, 32'd17);
        for (int i = 0; i < 4; i++) pipe[i] = '{default: '0};
        dcur = mk(1'b0, 3'd0, 8'd0, 32'd0);
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_func3 = '0; bus.d_addr = '0; bus.d_wdata = '0;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_outs("rst");
        @(negedge clk);
        rst = 1'b1;

        // Fetch with unaligned low bits
        fq.push_back(8'h03);
        run(5);
        // lw then lb back-to-back on word 0
        dq.push_back(mk(1'b0, 3'd2, 8'd0, 32'd0));
        dq.push_back(mk(1'b0, 3'd0, 8'd0, 32'd0));
        run(6);
        // Store followed immediately by a load of the same word
        dq.push_back(mk(1'b1, 3'd2, 8'd4, 32'hDEAD_BEEF));
        dq.push_back(mk(1'b0, 3'd2, 8'd4, 32'd0));
        run(6);
        // Faults: misaligned lw, misaligned sh, store with bu width
        dq.push_back(mk(1'b0, 3'd2, 8'd2, 32'd0));
        dq.push_back(mk(1'b1, 3'd1, 8'd1, 32'h1234));
        dq.push_back(mk(1'b1, 3'd4, 8'd0, 32'h55));
        run(7);

        // Both requesters saturated: fetch should win one cycle in five
        p_f = 100; p_d = 100;
        fbase = n_f_grants;
        run(25);
        check("fair_pattern", 32'(n_f_grants - fbase), 32'd5);
        p_f = 0; p_d = 0;
        run(4);

        // Randomized mixed traffic
        p_f = 50; p_d = 60;
        run(2000);
        p_f = 0; p_d = 0;
        run(5);

        // Reset while a store sits in the issue stage
        old_w = dmem_w[2];
        for (int i = 0; i < 4; i++) old_b[i] = ref_b[8 + i];
        dq.push_back(mk(1'b1, 3'd2, 8'd8, 32'hCAFE_F00D));
        step();
        check("pre_rst_m_we", 32'(bus.m_we), 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_outs("mid_rst");
        @(posedge clk);
        #1 check("rst_mem_kept", dmem_w[2], old_w);
        for (int i = 0; i < 4; i++) ref_b[8 + i] = old_b[i];
        for (int i = 0; i < 4; i++) pipe[i] = '{default: '0};
        d_streak = 0; last_if = '0; last_d = '0;
        f_pend = 0; d_pend = 0;
        @(negedge clk);
        rst = 1'b1;
        fq.push_back(8'h10);
        dq.push_back(mk(1'b0, 3'd2, 8'd8, 32'd0));
        run(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
